// File: rtl/color_scan_controller.sv
// Colour sensor scan controller: steps S2/S3 through red, green and blue, counts
// colorsignal rising edges in a fixed gate per filter and reports the dominant colour.
module color_scan_controller #(
  parameter int SETTLE_CYCLES = 10000,
  parameter int GATE_CYCLES   = 100000,
  parameter int CNT_W         = 16,
  parameter int MIN_COUNT     = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             colorsignal,
  output logic             s2,
  output logic             s3,
  output logic [CNT_W-1:0] red_count,
  output logic [CNT_W-1:0] green_count,
  output logic [CNT_W-1:0] blue_count,
  output logic [1:0]       top_color,
  output logic             valid,
  output logic             busy
);

  // state  | meaning
  // IDLE   | filter on clear, waiting for enable
  // SETTLE | filter just switched, photodiode settling, no counting
  // GATE   | counting colorsignal rising edges for channel ch
  // DECIDE | all three shadows captured, winner being picked

  localparam int MAX_CYC = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_GATE, ST_DECIDE} state_t;
  typedef enum logic [1:0] {CH_R, CH_G, CH_B} ch_t;

  state_t           state_q, state_d;
  ch_t              ch_q, ch_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] work_q, work_d;
  logic [CNT_W-1:0] sh_r_q, sh_r_d, sh_g_q, sh_g_d, sh_b_q, sh_b_d;
  logic [CNT_W-1:0] red_d, green_d, blue_d;
  logic [1:0]       top_d;
  logic             valid_d;
  logic [2:0]       sync_q;
  logic             edge_det;
  logic [CNT_W-1:0] gate_cnt;
  logic [CNT_W-1:0] win_cnt;
  logic [1:0]       win_code;

  // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the previous sample
  assign edge_det = sync_q[1] & ~sync_q[2];
  assign gate_cnt = (edge_det && work_q != CNT_MAX) ? work_q + CNT_W'(1) : work_q;
  assign busy     = (state_q != ST_IDLE);

  always_comb begin
    win_code = 2'd1;
    win_cnt  = sh_r_q;
    if (sh_g_q > win_cnt) begin
      win_code = 2'd2;
      win_cnt  = sh_g_q;
    end
    if (sh_b_q > win_cnt) begin
      win_code = 2'd3;
      win_cnt  = sh_b_q;
    end
    if (32'(win_cnt) < MIN_COUNT) win_code = 2'd0;
  end

  always_comb begin
    {s2, s3} = 2'b10;
    if (state_q != ST_IDLE) begin
      case (ch_q)
        CH_R:    {s2, s3} = 2'b00;
        CH_G:    {s2, s3} = 2'b11;
        default: {s2, s3} = 2'b01;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    tmr_d   = tmr_q;
    work_d  = work_q;
    sh_r_d  = sh_r_q;
    sh_g_d  = sh_g_q;
    sh_b_d  = sh_b_q;
    red_d   = red_count;
    green_d = green_count;
    blue_d  = blue_count;
    top_d   = top_color;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_SETTLE;
          ch_d    = CH_R;
          tmr_d   = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (tmr_q == '0) begin
          state_d = ST_GATE;
          tmr_d   = GATE_LOAD;
          work_d  = '0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_GATE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else begin
          work_d = gate_cnt;
          if (tmr_q == '0) begin
            // the final gate cycle's edge is already folded into gate_cnt
            case (ch_q)
              CH_R: begin
                sh_r_d  = gate_cnt;
                ch_d    = CH_G;
                state_d = ST_SETTLE;
                tmr_d   = SETTLE_LOAD;
              end
              CH_G: begin
                sh_g_d  = gate_cnt;
                ch_d    = CH_B;
                state_d = ST_SETTLE;
                tmr_d   = SETTLE_LOAD;
              end
              default: begin
                sh_b_d  = gate_cnt;
                state_d = ST_DECIDE;
              end
            endcase
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
      end
      default: begin
        red_d   = sh_r_q;
        green_d = sh_g_q;
        blue_d  = sh_b_q;
        top_d   = win_code;
        valid_d = 1'b1;
        ch_d    = CH_R;
        if (enable) begin
          state_d = ST_SETTLE;
          tmr_d   = SETTLE_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      sync_q      <= '0;
      state_q     <= ST_IDLE;
      ch_q        <= CH_R;
      tmr_q       <= '0;
      work_q      <= '0;
      sh_r_q      <= '0;
      sh_g_q      <= '0;
      sh_b_q      <= '0;
      red_count   <= '0;
      green_count <= '0;
      blue_count  <= '0;
      top_color   <= 2'd0;
      valid       <= 1'b0;
    end else begin
      sync_q      <= {sync_q[1:0], colorsignal};
      state_q     <= state_d;
      ch_q        <= ch_d;
      tmr_q       <= tmr_d;
      work_q      <= work_d;
      sh_r_q      <= sh_r_d;
      sh_g_q      <= sh_g_d;
      sh_b_q      <= sh_b_d;
      red_count   <= red_d;
      green_count <= green_d;
      blue_count  <= blue_d;
      top_color   <= top_d;
      valid       <= valid_d;
    end
  end

endmodule

// File: tb/tb_color_scan_controller.sv
// Self-checking bench for color_scan_controller: table vectors, randomized scans
// against a count/priority reference model, and abort/reset/settle corner cases.
module tb_color_scan_controller;

  typedef struct {
    int nr, ng, nb;
    int er, eg, eb, et;
  } vec_t;

  logic       clock;
  logic       rst_n;
  logic       en8, cs8, en4, cs4;
  logic       s2_8, s3_8, s2_4, s3_4;
  logic [7:0] red8, green8, blue8;
  logic [3:0] red4, green4, blue4;
  logic [1:0] top8, top4;
  logic       valid8, valid4, busy8, busy4;

  logic       sel4;
  logic [1:0] o_f, o_top;
  logic [7:0] o_r, o_g, o_b;
  logic       o_valid, o_busy;

  int n_checks = 0;
  int n_pass   = 0;

  color_scan_controller #(.SETTLE_CYCLES(4), .GATE_CYCLES(20), .CNT_W(8), .MIN_COUNT(3)) dut8 (
    .clock(clock), .rst_n(rst_n), .enable(en8), .colorsignal(cs8), .s2(s2_8), .s3(s3_8),
    .red_count(red8), .green_count(green8), .blue_count(blue8), .top_color(top8),
    .valid(valid8), .busy(busy8));

  // narrow counters with a longer gate so the red channel can saturate
  color_scan_controller #(.SETTLE_CYCLES(4), .GATE_CYCLES(48), .CNT_W(4), .MIN_COUNT(3)) dut4 (
    .clock(clock), .rst_n(rst_n), .enable(en4), .colorsignal(cs4), .s2(s2_4), .s3(s3_4),
    .red_count(red4), .green_count(green4), .blue_count(blue4), .top_color(top4),
    .valid(valid4), .busy(busy4));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    if (sel4) begin
      o_f = {s2_4, s3_4}; o_r = {4'd0, red4}; o_g = {4'd0, green4}; o_b = {4'd0, blue4};
      o_top = top4; o_valid = valid4; o_busy = busy4;
    end else begin
      o_f = {s2_8, s3_8}; o_r = red8; o_g = green8; o_b = blue8;
      o_top = top8; o_valid = valid8; o_busy = busy8;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // counts saturate at the counter width; strict maximum wins, ties go red > green > blue
  function automatic vec_t model(input int a, input int b, input int c, input int w);
    vec_t v;
    int cap, best;
    cap  = (1 << w) - 1;
    v.nr = a; v.ng = b; v.nb = c;
    v.er = (a > cap) ? cap : a;
    v.eg = (b > cap) ? cap : b;
    v.eb = (c > cap) ? cap : c;
    v.et = 1; best = v.er;
    if (v.eg > best) begin v.et = 2; best = v.eg; end
    if (v.eb > best) begin v.et = 3; best = v.eb; end
    if (best < 3) v.et = 0;
    return v;
  endfunction

  // mode 0: full scan; 1: drop enable after sample stop_j; 2: reset after sample stop_j.
  // Sample j is taken just after the j-th edge counted from the one that sees enable high.
  task automatic do_scan(input bit use4, input vec_t v, input int mode, input int stop_j,
                         input bit settle_pat);
    int per, last, c, off;
    int n[3];
    bit w[0:255];
    bit busy_ok, valid_ok, filt_ok;
    logic [1:0] ef;
    per  = use4 ? 52 : 24;
    last = 3 * per + 1;
    n[0] = v.nr; n[1] = v.ng; n[2] = v.nb;
    sel4 = use4;
    // a rise whose first high sample is at offset 3..per-2 of a channel lands in its gate
    for (int j = 0; j <= last; j++) begin
      c = j / per; off = j % per; w[j] = 1'b0;
      if (c < 3) begin
        if (settle_pat) w[j] = (off == 0) || (off == 2 && c < 2);
        else w[j] = (off >= 4) && (off % 2 == 0) && ((off - 4) / 2 < n[c]);
      end
    end
    busy_ok = 1'b1; valid_ok = 1'b1; filt_ok = 1'b1;
    @(posedge clock); #1;
    if (use4) en4 = 1'b1; else en8 = 1'b1;
    for (int j = 0; j <= last; j++) begin
      if (use4) cs4 = w[j]; else cs8 = w[j];
      @(posedge clock); #1;
      c  = (j / per > 2) ? 2 : j / per;
      ef = (j == last) ? 2'b00 : (c == 0) ? 2'b00 : (c == 1) ? 2'b11 : 2'b01;
      if (o_f !== ef) filt_ok = 1'b0;
      if (o_busy !== 1'b1) busy_ok = 1'b0;
      if (o_valid !== (j == last)) valid_ok = 1'b0;
      if (mode != 0 && j == stop_j) break;
    end
    check("filter_seq", filt_ok, 1);
    check("busy_window", busy_ok, 1);
    check("valid_timing", valid_ok, 1);
    if (mode == 0) begin
      check("red_count", o_r, v.er);
      check("green_count", o_g, v.eg);
      check("blue_count", o_b, v.eb);
      check("top_color", o_top, v.et);
    end
    if (mode == 2) rst_n = 1'b0;
    if (use4) begin en4 = 1'b0; cs4 = 1'b0; end
    else begin en8 = 1'b0; cs8 = 1'b0; end
    @(posedge clock); #1;
    rst_n = 1'b1;
    check("idle_busy", o_busy, 0);
    check("idle_filter", o_f, 2'b10);
    check("idle_valid", o_valid, 0);
    check("held_red", o_r, v.er);
    check("held_green", o_g, v.eg);
    check("held_blue", o_b, v.eb);
    check("held_top", o_top, v.et);
    valid_ok = 1'b1;
    repeat (per) begin
      @(posedge clock); #1;
      if (o_valid !== 1'b0 || o_busy !== 1'b0) valid_ok = 1'b0;
    end
    check("quiet_after", valid_ok, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    vec_t v, last_pub;
    rst_n = 1'b0; en8 = 1'b0; cs8 = 1'b0; en4 = 1'b0; cs4 = 1'b0; sel4 = 1'b0;
    tbl[0] = '{10, 4, 2, 10, 4, 2, 1};
    tbl[1] = '{1, 6, 6, 1, 6, 6, 2};
    tbl[2] = '{2, 2, 2, 2, 2, 2, 0};
    tbl[3] = '{0, 0, 9, 0, 0, 9, 3};
    tbl[4] = '{3, 3, 3, 3, 3, 3, 1};
    tbl[5] = '{5, 9, 9, 5, 9, 9, 2};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 0};
    tbl[7] = '{4, 7, 5, 4, 7, 5, 2};

    repeat (3) @(posedge clock);
    #1;
    check("rst_s2", s2_8, 1);
    check("rst_s3", s3_8, 0);
    check("rst_red", red8, 0);
    check("rst_green", green8, 0);
    check("rst_blue", blue8, 0);
    check("rst_top", top8, 0);
    check("rst_valid", valid8, 0);
    check("rst_busy", busy8, 0);
    check("rst_busy4", busy4, 0);
    check("rst_red4", red4, 0);
    rst_n = 1'b1;
    @(posedge clock); #1;
    check("idle_after_rst", busy8, 0);

    for (int i = 0; i < 8; i++) begin
      do_scan(1'b0, tbl[i], 0, 0, 1'b0);
      last_pub = tbl[i];
    end

    repeat (6) begin
      v = model(int'($urandom_range(0, 10)), int'($urandom_range(0, 10)),
                int'($urandom_range(0, 10)), 8);
      do_scan(1'b0, v, 0, 0, 1'b0);
      last_pub = v;
    end

    // enable dropped in the green gate: published values must be the previous scan's
    v = '{7, 7, 7, last_pub.er, last_pub.eg, last_pub.eb, last_pub.et};
    do_scan(1'b0, v, 1, 34, 1'b0);
    do_scan(1'b0, tbl[0], 0, 0, 1'b0);

    do_scan(1'b1, model(20, 2, 17, 4), 0, 0, 1'b0);

    // reset while in DECIDE, then edges confined to the settle windows
    do_scan(1'b0, '{9, 4, 4, 0, 0, 0, 0}, 2, 72, 1'b0);
    do_scan(1'b0, '{0, 0, 0, 0, 0, 0, 0}, 0, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
